// File: rtl/hybrid_cpu_pkg.sv
// Shared definitions for the hybrid core instruction-memory path:
// memory geometry, requester ids and the fetch-arbiter state encoding.
package hybrid_cpu_pkg;

  localparam int unsigned IMEM_DEPTH = 128;
  localparam int unsigned IMEM_IDX_W = 7;

  localparam logic REQ_RV  = 1'b0;
  localparam logic REQ_X86 = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/imem_fetch_arbiter_if.sv
// Fetch-side and instr_mem-side bus of the instruction-memory arbiter.
// slave = arbiter view; master = front ends plus memory.
interface imem_fetch_arbiter_if;
  import hybrid_cpu_pkg::*;

  logic                  rv_req;
  logic [63:0]           rv_addr;
  logic                  rv_gnt;
  logic                  rv_rvalid;
  logic [31:0]           rv_rdata;
  logic                  x86_req;
  logic [63:0]           x86_addr;
  logic                  x86_gnt;
  logic                  x86_rvalid;
  logic [31:0]           x86_rdata;
  logic                  mem_en;
  logic [IMEM_IDX_W-1:0] mem_addr;
  logic [31:0]           mem_rdata;

  modport slave (
    input  rv_req, rv_addr, x86_req, x86_addr, mem_rdata,
    output rv_gnt, rv_rvalid, rv_rdata, x86_gnt, x86_rvalid, x86_rdata,
           mem_en, mem_addr
  );

  modport master (
    output rv_req, rv_addr, x86_req, x86_addr, mem_rdata,
    input  rv_gnt, rv_rvalid, rv_rdata, x86_gnt, x86_rvalid, x86_rdata,
           mem_en, mem_addr
  );

endinterface

// File: rtl/imem_arb_starve_ctr.sv
// Saturating 8-bit lost-arbitration counter; clr has priority over inc.
module imem_arb_starve_ctr #(
  parameter logic [7:0] MAX = 8'd8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && (cnt_q != MAX))
      cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign at_max = (cnt_q == MAX);

endmodule

// File: rtl/imem_fetch_arbiter.sv
// Arbitrates the single-ported instr_mem between the RISC-V and x86 fetch
// paths, one read in flight. Optional grant counters: IMEM_ARB_STATS_EN.
module imem_fetch_arbiter
  import hybrid_cpu_pkg::*;
#(
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 x86_mode_active,
  imem_fetch_arbiter_if.slave  bus,
  output logic                 busy
`ifdef IMEM_ARB_STATS_EN
  ,
  output logic [31:0]          rv_grant_cnt,
  output logic [31:0]          x86_grant_cnt
`endif
);

  localparam logic [1:0] LAT_INIT = 2'(MEM_LAT - 1);

  arb_state_e      state_q, state_d;
  logic [1:0]      lat_q, lat_d;
  logic            win_q, win_d, win;
  logic [31:0]     rv_rdata_q, rv_rdata_d, x86_rdata_q, x86_rdata_d;
  logic            rv_gnt, x86_gnt, rv_rvalid, x86_rvalid, mem_en;
  logic [IMEM_IDX_W-1:0] mem_addr;
  logic            rv_inc, x86_inc, rv_at_max, x86_at_max;

  // Gating on rst_n keeps the combinational grant path quiet while reset is held.
  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    win_d       = win_q;
    rv_rdata_d  = rv_rdata_q;
    x86_rdata_d = x86_rdata_q;
    win         = REQ_RV;
    rv_gnt      = 1'b0;
    x86_gnt     = 1'b0;
    rv_rvalid   = 1'b0;
    x86_rvalid  = 1'b0;
    mem_en      = 1'b0;
    mem_addr    = '0;
    rv_inc      = 1'b0;
    x86_inc     = 1'b0;
    case (state_q)
      IDLE: begin
        if (rst_n && (bus.rv_req || bus.x86_req)) begin
          if (bus.rv_req && bus.x86_req) begin
            if (x86_mode_active) win = rv_at_max  ? REQ_RV  : REQ_X86;
            else                 win = x86_at_max ? REQ_X86 : REQ_RV;
          end else begin
            win = bus.x86_req ? REQ_X86 : REQ_RV;
          end
          rv_gnt   = (win == REQ_RV);
          x86_gnt  = (win == REQ_X86);
          rv_inc   = bus.rv_req  && x86_gnt;
          x86_inc  = bus.x86_req && rv_gnt;
          mem_en   = 1'b1;
          mem_addr = (win == REQ_X86) ? bus.x86_addr[IMEM_IDX_W+1:2]
                                      : bus.rv_addr[IMEM_IDX_W+1:2];
          lat_d    = LAT_INIT;
          win_d    = win;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (lat_q == '0) begin
          if (win_q == REQ_X86) x86_rdata_d = bus.mem_rdata;
          else                  rv_rdata_d  = bus.mem_rdata;
          state_d = RESP;
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end
      RESP: begin
        rv_rvalid  = (win_q == REQ_RV);
        x86_rvalid = (win_q == REQ_X86);
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lat_q       <= '0;
      win_q       <= REQ_RV;
      rv_rdata_q  <= '0;
      x86_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      win_q       <= win_d;
      rv_rdata_q  <= rv_rdata_d;
      x86_rdata_q <= x86_rdata_d;
    end
  end

  imem_arb_starve_ctr #(.MAX(8'(STARVE_MAX))) u_rv_starve (
    .clk(clk), .rst_n(rst_n), .inc(rv_inc), .clr(rv_gnt), .at_max(rv_at_max)
  );

  imem_arb_starve_ctr #(.MAX(8'(STARVE_MAX))) u_x86_starve (
    .clk(clk), .rst_n(rst_n), .inc(x86_inc), .clr(x86_gnt), .at_max(x86_at_max)
  );

`ifdef IMEM_ARB_STATS_EN
  logic [31:0] rv_cnt_q, rv_cnt_d, x86_cnt_q, x86_cnt_d;

  always_comb begin
    rv_cnt_d  = rv_cnt_q  + (rv_gnt  ? 32'd1 : 32'd0);
    x86_cnt_d = x86_cnt_q + (x86_gnt ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rv_cnt_q  <= '0;
      x86_cnt_q <= '0;
    end else begin
      rv_cnt_q  <= rv_cnt_d;
      x86_cnt_q <= x86_cnt_d;
    end
  end

  assign rv_grant_cnt  = rv_cnt_q;
  assign x86_grant_cnt = x86_cnt_q;
`endif

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.rv_addr[63:IMEM_IDX_W+2], bus.rv_addr[1:0],
                              bus.x86_addr[63:IMEM_IDX_W+2], bus.x86_addr[1:0]};

  assign bus.rv_gnt     = rv_gnt;
  assign bus.x86_gnt    = x86_gnt;
  assign bus.rv_rvalid  = rv_rvalid;
  assign bus.x86_rvalid = x86_rvalid;
  assign bus.rv_rdata   = rv_rdata_q;
  assign bus.x86_rdata  = x86_rdata_q;
  assign bus.mem_en     = mem_en;
  assign bus.mem_addr   = mem_addr;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Scoreboard bench for imem_fetch_arbiter: one instance at MEM_LAT=1 for
// arbitration/starvation, one at MEM_LAT=3 for reset-during-read.
module tb_imem_fetch_arbiter;
  import hybrid_cpu_pkg::*;

  localparam int unsigned LAT1 = 1;
  localparam int unsigned LAT3 = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mode1 = 1'b0;
  logic mode3 = 1'b0;
  logic busy1, busy3;
  always #5 clk = ~clk;

  imem_fetch_arbiter_if bus1 ();
  imem_fetch_arbiter_if bus3 ();

`ifdef IMEM_ARB_STATS_EN
  logic [31:0] rvc1, xc1, rvc3, xc3;
`endif

  imem_fetch_arbiter #(.MEM_LAT(LAT1), .STARVE_MAX(8)) u1 (
    .clk(clk), .rst_n(rst_n), .x86_mode_active(mode1), .bus(bus1), .busy(busy1)
`ifdef IMEM_ARB_STATS_EN
    , .rv_grant_cnt(rvc1), .x86_grant_cnt(xc1)
`endif
  );

  imem_fetch_arbiter #(.MEM_LAT(LAT3), .STARVE_MAX(8)) u3 (
    .clk(clk), .rst_n(rst_n), .x86_mode_active(mode3), .bus(bus3), .busy(busy3)
`ifdef IMEM_ARB_STATS_EN
    , .rv_grant_cnt(rvc3), .x86_grant_cnt(xc3)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [6:0] idx);
    if (idx == 7'd2) return 32'h00200113;
    return 32'hC0DE_0000 + 32'(idx) * 32'h111;
  endfunction

  // instr_mem models: data valid LAT cycles after the read strobe
  logic [31:0] pipe1 [4];
  logic [31:0] pipe3 [4];
  always @(posedge clk) begin
    pipe1[0] <= mem_word(bus1.mem_addr);
    pipe3[0] <= mem_word(bus3.mem_addr);
    for (int k = 1; k < 4; k++) begin
      pipe1[k] <= pipe1[k-1];
      pipe3[k] <= pipe3[k-1];
    end
  end
  assign bus1.mem_rdata = pipe1[LAT1-1];
  assign bus3.mem_rdata = pipe3[LAT3-1];

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    logic        side;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t q1[$];
  exp_t q3[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic mon_pop(input string tag, input logic rv_v, input logic x_v,
                         input logic [31:0] rv_d, input logic [31:0] x_d,
                         inout exp_t q[$]);
    exp_t e;
    if (q.size() == 0) begin
      chk({tag, "_spurious_rvalid"}, {62'd0, rv_v, x_v}, 64'd0);
    end else begin
      e = q.pop_front();
      chk({tag, "_rvalid_side"}, {62'd0, rv_v, x_v}, (e.side == REQ_X86) ? 64'd1 : 64'd2);
      chk({tag, "_rdata"}, (e.side == REQ_X86) ? x_d : rv_d, e.data);
      chk({tag, "_rvalid_cycle"}, 64'(cyc), 64'(e.cyc));
    end
  endtask

  always @(negedge clk) begin
    if (bus1.rv_rvalid || bus1.x86_rvalid)
      mon_pop("u1", bus1.rv_rvalid, bus1.x86_rvalid, bus1.rv_rdata, bus1.x86_rdata, q1);
    if (bus3.rv_rvalid || bus3.x86_rvalid)
      mon_pop("u3", bus3.rv_rvalid, bus3.x86_rvalid, bus3.rv_rdata, bus3.x86_rdata, q3);
  end

  // Wait (bounded) for the next grant on u1, check it, queue the response.
  task automatic arb1(input logic side, input logic [6:0] idx);
    int t = 0;
    @(negedge clk);
    while (!(bus1.rv_gnt || bus1.x86_gnt) && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("u1_rv_gnt", bus1.rv_gnt, side == REQ_RV);
    chk("u1_x86_gnt", bus1.x86_gnt, side == REQ_X86);
    chk("u1_mem_en", bus1.mem_en, 1);
    chk("u1_mem_addr", bus1.mem_addr, idx);
    q1.push_back('{side, mem_word(idx), cyc + int'(LAT1) + 1});
    @(posedge clk); #1;
  endtask

  task automatic arb3(input logic [6:0] idx);
    int t = 0;
    @(negedge clk);
    while (!bus3.rv_gnt && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("u3_rv_gnt", bus3.rv_gnt, 1);
    chk("u3_mem_addr", bus3.mem_addr, idx);
    q3.push_back('{REQ_RV, mem_word(idx), cyc + int'(LAT3) + 1});
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int t = 0;
    while ((q1.size() != 0 || q3.size() != 0) && t < 30) begin
      @(negedge clk);
      t++;
    end
    chk("drain_q1_empty", 64'(q1.size()), 0);
    chk("drain_q3_empty", 64'(q3.size()), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    bus1.rv_req = 0; bus1.rv_addr = '0; bus1.x86_req = 0; bus1.x86_addr = '0;
    bus3.rv_req = 0; bus3.rv_addr = '0; bus3.x86_req = 0; bus3.x86_addr = '0;

    #12;
    chk("rst_gnts", {bus1.rv_gnt, bus1.x86_gnt}, 0);
    chk("rst_rvalids", {bus1.rv_rvalid, bus1.x86_rvalid}, 0);
    chk("rst_rdata", {bus1.rv_rdata, bus1.x86_rdata}, 0);
    chk("rst_mem", {bus1.mem_en, bus1.mem_addr}, 0);
    chk("rst_busy", busy1, 0);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;

    // single RV fetch, index 2
    bus1.rv_req = 1; bus1.rv_addr = 64'h8;
    arb1(REQ_RV, 7'd2);
    bus1.rv_req = 0;
    @(negedge clk); chk("busy_t1", busy1, 1);
    @(negedge clk); chk("busy_t2", busy1, 1); chk("rvalid_t2", bus1.rv_rvalid, 1);
    @(negedge clk); chk("busy_t3", busy1, 0);
    @(posedge clk); #1;

    // starvation: x86 preferred, both always requesting
    mode1 = 1;
    bus1.rv_req = 1;  bus1.rv_addr  = 64'h10;
    bus1.x86_req = 1; bus1.x86_addr = 64'h20;
    for (int i = 0; i < 8; i++) arb1(REQ_X86, 7'd8);
    arb1(REQ_RV, 7'd4);
    for (int i = 0; i < 8; i++) arb1(REQ_X86, 7'd8);
    arb1(REQ_RV, 7'd4);

    // mode change during an in-flight RV read
    mode1 = 0; bus1.rv_addr = 64'h1C;
    arb1(REQ_RV, 7'd7);
    mode1 = 1;
    arb1(REQ_X86, 7'd8);
    bus1.rv_req = 0; bus1.x86_req = 0;

    // byte-granular rip with high bits set wraps to index 1
    mode1 = 0;
    @(posedge clk); #1;
    bus1.x86_req = 1; bus1.x86_addr = 64'h400005;
    arb1(REQ_X86, 7'd1);
    bus1.x86_req = 0;
    drain();

`ifdef IMEM_ARB_STATS_EN
    chk("stats_rv", rvc1, 32'd4);
    chk("stats_x86", xc1, 32'd18);
`endif

    // MEM_LAT=3: one full read, then reset in the middle of a second one
    bus3.rv_req = 1; bus3.rv_addr = 64'h14;
    arb3(7'd5);
    bus3.rv_req = 0;
    drain();
    bus3.rv_req = 1; bus3.rv_addr = 64'hC;
    arb3(7'd3);
    rst_n = 0;
    void'(q3.pop_back());
    #1;
    chk("u3_rst_gnt", {bus3.rv_gnt, bus3.x86_gnt}, 0);
    chk("u3_rst_rvalid", {bus3.rv_rvalid, bus3.x86_rvalid}, 0);
    chk("u3_rst_rdata", {bus3.rv_rdata, bus3.x86_rdata}, 0);
    chk("u3_rst_mem", {bus3.mem_en, bus3.mem_addr}, 0);
    chk("u3_rst_busy", busy3, 0);
`ifdef IMEM_ARB_STATS_EN
    chk("stats_rst", {rvc1, xc1}, 0);
`endif
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    chk("u3_first_gnt", bus3.rv_gnt, 1);
    chk("u3_first_addr", bus3.mem_addr, 3);
    if (bus3.rv_gnt) q3.push_back('{REQ_RV, mem_word(7'd3), cyc + int'(LAT3) + 1});
    @(posedge clk); #1;
    bus3.rv_req = 0;
    drain();
    repeat (4) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_fetch_arbiter.md
Name: imem_fetch_arbiter

Overview:
- Shares the single-ported 128-word instruction memory between the RISC-V fetch path and the x86 fetch path of the hybrid core.
- Sequences one outstanding read at a time. The preferred requester follows the current execution mode.
- A starvation guard prevents the idle-mode front end from being locked out.
- Sits between both fetch front ends and the instr_mem read port.

Parameters:
- MEM_LAT, 1, instr_mem read latency in cycles (legal 1..4); mem_rdata valid MEM_LAT cycles after mem_en.
- STARVE_MAX, 8, consecutive lost arbitrations before the non-preferred requester is forced to win (legal 1..255).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- x86_mode_active  in  1  1 = x86 preferred, 0 = RISC-V preferred
- rv_req  in  1  RISC-V fetch request; held with rv_addr until rv_gnt
- rv_addr  in  64  RISC-V fetch byte address (pc)
- rv_gnt  out  1  request accepted this cycle
- rv_rvalid  out  1  one-cycle pulse; rv_rdata valid
- rv_rdata  out  32  fetched word
- x86_req  in  1  x86 fetch request; held with x86_addr until x86_gnt
- x86_addr  in  64  x86 fetch byte address (rip)
- x86_gnt  out  1  request accepted this cycle
- x86_rvalid  out  1  one-cycle pulse; x86_rdata valid
- x86_rdata  out  32  fetched word
- mem_en  out  1  instr_mem read strobe
- mem_addr  out  7  instr_mem word index
- mem_rdata  in  32  instr_mem read data
- busy  out  1  a read is outstanding (state != IDLE)

Behaviour:
- Reset is asynchronous. On reset assertion: FSM goes to IDLE and all outputs are 0, including the rdata registers. Both starvation counters are cleared. Any in-flight read is discarded and produces no rvalid after reset release.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: if any req, choose a winner, assert its gnt, mem_en=1 and mem_addr=winner_addr[8:2] combinationally in the same cycle, load lat_cnt=MEM_LAT-1, latch the winner id, and go to WAIT.
  - WAIT: decrement lat_cnt. When lat_cnt==0, capture mem_rdata into the winner's rdata register and go to RESP.
  - RESP: pulse the winner's rvalid for one cycle, go to IDLE. No arbitration happens in RESP.
- Latency: gnt at cycle T, rvalid at cycle T+MEM_LAT+1. Issue rate is at most one read per MEM_LAT+2 cycles.
- gnt is asserted only in IDLE, and to exactly one requester. mem_en is asserted only in IDLE with a grant.
- Winner selection:
  - One requester: it wins.
  - Both requesting: the preferred requester (x86 if x86_mode_active, else RV) wins, unless the other requester's starve count equals STARVE_MAX, in which case the other wins.
  - x86_mode_active is sampled only in IDLE. A change during WAIT/RESP does not affect the transaction in flight.
- Starvation counters (one per requester, 8-bit):
  - Increment in an IDLE arbitration cycle where that side requests and loses. Saturate at STARVE_MAX.
  - Clear when that side is granted.
  - Hold otherwise.
- Address: mem_addr = addr[8:2]. addr[1:0] and addr[63:9] are ignored, so addresses wrap modulo 512 bytes (e.g. 0x400000 maps to index 0). x86 byte-granular rip returns the containing aligned word.
- rdata registers hold their last value until the next capture for that side.
- A requester dropping req before gnt is legal: the request is withdrawn with no side effects.

Optional Feature:
- Macro: IMEM_ARB_STATS_EN.
- When defined: adds outputs rv_grant_cnt[31:0] and x86_grant_cnt[31:0]. Each increments on its side's gnt, wraps at 2^32, and resets to 0.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package hybrid_cpu_pkg holds:
  - IMEM_DEPTH=128 and IMEM_IDX_W=7
  - requester id constants REQ_RV=0 and REQ_X86=1
  - FSM state encoding: IDLE=2'd0, WAIT=2'd1, RESP=2'd2
- One natural sub-module: imem_arb_starve_ctr, a saturating 8-bit counter with inc/clr inputs and an at_max output, instantiated twice.

Test Plan:
- MEM_LAT=1; rv_req with rv_addr=0x8, mem holds 0x00200113 at index 2 -> rv_gnt at T, mem_addr=2, rv_rvalid and rv_rdata=0x00200113 at T+2, busy high T+1..T+2.
- Both req every cycle, x86_mode_active=1, STARVE_MAX=8 -> x86 wins 8 arbitrations, RV wins the 9th, then x86 resumes; the RV counter clears on that grant.
- Both req, x86_mode_active toggles 0->1 during WAIT -> in-flight RV read completes to rv_rdata; the next arbitration grants x86.
- x86_addr=0x400005 -> mem_addr=1, the returned word appears on x86_rdata only, and rv_rvalid stays 0.
- rst_n pulled low during WAIT (MEM_LAT=3) -> all outputs 0 immediately, no rvalid after release, and the first post-reset request is granted in its first IDLE cycle.
- With IMEM_ARB_STATS_EN: 5 RV and 3 x86 grants -> rv_grant_cnt=5, x86_grant_cnt=3; after reset both are 0.
